// File: rtl/drive_arbiter.sv
// Motor-channel arbiter: picks IR-remote or camera control, applies gear and e-stop,
// and ramps each wheel's duty/direction toward the selected drive command.
module drive_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned LOST_CYCLES    = 25_000_000,
  parameter int unsigned RAMP_DIV       = 50_000,
  parameter int unsigned RAMP_STEP      = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ir_valid,
  input  logic [7:0] ir_code,
  input  logic       cam_found,
  input  logic [1:0] cam_dir,
  input  logic       e_stop,
  output logic [1:0] mode,
  output logic [1:0] cam_state,
  output logic [2:0] drive_cmd,
  output logic [1:0] gear,
  output logic [7:0] duty_l,
  output logic [7:0] duty_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       moving
);

  localparam int unsigned WdW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LostW = (LOST_CYCLES > 2) ? $clog2(LOST_CYCLES) : 1;
  localparam int unsigned TickW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

  localparam logic [WdW-1:0]   WdMax   = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [LostW-1:0] LostMax = LostW'(LOST_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(RAMP_DIV - 1);
  localparam logic [8:0]       Step    = 9'(RAMP_STEP);

  localparam logic [7:0] KeyIr     = 8'h0F;
  localparam logic [7:0] KeyCam    = 8'h13;
  localparam logic [7:0] KeyIdle   = 8'h10;
  localparam logic [7:0] KeyFwd    = 8'h05;
  localparam logic [7:0] KeyLeft   = 8'h07;
  localparam logic [7:0] KeyRight  = 8'h09;
  localparam logic [7:0] KeyArcL   = 8'h04;
  localparam logic [7:0] KeyArcR   = 8'h06;
  localparam logic [7:0] KeyStop   = 8'h08;
  localparam logic [7:0] KeyGearUp = 8'h1A;
  localparam logic [7:0] KeyGearDn = 8'h1E;
  localparam logic [7:0] KeyPause  = 8'h1B;
  localparam logic [7:0] KeyResume = 8'h1F;

  typedef enum logic [1:0] {ModeIdle = 2'd0, ModeIr = 2'd1, ModeCam = 2'd2} mode_e;
  typedef enum logic [1:0] {CamSearch = 2'd0, CamFollow = 2'd1, CamPause = 2'd3} cam_e;
  typedef enum logic [2:0] {
    CmdStop = 3'd0, CmdFwd = 3'd1, CmdLeft = 3'd2, CmdRight = 3'd3, CmdArcL = 3'd4, CmdArcR = 3'd5
  } cmd_e;

  mode_e            mode_q, mode_d;
  cam_e             cam_q, cam_d;
  cmd_e             cmd_q, cmd_d;
  logic [1:0]       gear_q, gear_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [LostW-1:0] lost_q, lost_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [7:0]       duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic             dir_l_q, dir_l_d, dir_r_q, dir_r_d;

  // Button decode
  logic  key_is_mode, key_is_drive;
  mode_e key_mode;
  cmd_e  key_cmd;

  always_comb begin
    key_is_mode  = 1'b0;
    key_is_drive = 1'b0;
    key_mode     = mode_q;
    key_cmd      = CmdStop;
    if (ir_valid) begin
      case (ir_code)
        KeyIr:    begin key_is_mode  = 1'b1; key_mode = ModeIr;   end
        KeyCam:   begin key_is_mode  = 1'b1; key_mode = ModeCam;  end
        KeyIdle:  begin key_is_mode  = 1'b1; key_mode = ModeIdle; end
        KeyFwd:   begin key_is_drive = 1'b1; key_cmd  = CmdFwd;   end
        KeyLeft:  begin key_is_drive = 1'b1; key_cmd  = CmdLeft;  end
        KeyRight: begin key_is_drive = 1'b1; key_cmd  = CmdRight; end
        KeyArcL:  begin key_is_drive = 1'b1; key_cmd  = CmdArcL;  end
        KeyArcR:  begin key_is_drive = 1'b1; key_cmd  = CmdArcR;  end
        KeyStop:  begin key_is_drive = 1'b1; key_cmd  = CmdStop;  end
        default:  ;
      endcase
    end
  end

  cmd_e follow_cmd;
  always_comb begin
    case (cam_dir)
      2'd0:    follow_cmd = CmdArcL;
      2'd2:    follow_cmd = CmdArcR;
      default: follow_cmd = CmdFwd;
    endcase
  end

  // Mode / CAM FSM, gear, watchdog and lost counter
  always_comb begin
    mode_d = mode_q;
    cam_d  = cam_q;
    cmd_d  = cmd_q;
    gear_d = gear_q;
    wd_d   = wd_q;
    lost_d = lost_q;

    if (key_is_mode && (key_mode != mode_q)) begin
      mode_d = key_mode;
      cmd_d  = CmdStop;
      cam_d  = CamSearch;
      wd_d   = '0;
      lost_d = '0;
    end else begin
      if (ir_valid && (ir_code == KeyGearUp) && (gear_q != 2'd3)) gear_d = gear_q + 2'd1;
      if (ir_valid && (ir_code == KeyGearDn) && (gear_q != 2'd0)) gear_d = gear_q - 2'd1;

      case (mode_q)
        ModeIr: begin
          if (ir_valid) wd_d = '0;
          else if (wd_q != WdMax) wd_d = wd_q + 1'b1;

          if (e_stop) cmd_d = CmdStop;
          else if (key_is_drive) cmd_d = key_cmd;
          else if (!ir_valid && (wd_q == WdMax)) cmd_d = CmdStop;
        end

        ModeCam: begin
          // Pause/resume buttons yield to e_stop; tracking keeps running underneath.
          case (cam_q)
            CamSearch: begin
              if (ir_valid && !e_stop && (ir_code == KeyPause)) cam_d = CamPause;
              else if (cam_found) cam_d = CamFollow;
            end
            CamFollow: begin
              if (ir_valid && !e_stop && (ir_code == KeyPause)) cam_d = CamPause;
              else if (cam_found) lost_d = '0;
              else if (lost_q == LostMax) cam_d = CamSearch;
              else lost_d = lost_q + 1'b1;
            end
            CamPause: begin
              if (ir_valid && !e_stop && (ir_code == KeyResume)) cam_d = CamSearch;
            end
            default: cam_d = CamSearch;
          endcase

          if (cam_d != CamFollow) lost_d = '0;

          if (e_stop) cmd_d = CmdStop;
          else begin
            case (cam_d)
              CamSearch: cmd_d = CmdLeft;
              CamFollow: cmd_d = follow_cmd;
              default:   cmd_d = CmdStop;
            endcase
          end
        end

        default: cmd_d = CmdStop;
      endcase
    end
  end

  // Target duty/direction; SEARCH always spins at the lowest gear
  logic [1:0] gear_eff;
  logic [7:0] base, half, tgt_l, tgt_r;
  logic       tdir_l, tdir_r;

  always_comb begin
    gear_eff = ((mode_q == ModeCam) && (cam_q == CamSearch)) ? 2'd0 : gear_q;
    base     = {gear_eff, 6'h3F};
    half     = {1'b0, base[7:1]};
    tdir_l   = 1'b1;
    tdir_r   = 1'b1;
    tgt_l    = 8'd0;
    tgt_r    = 8'd0;
    case (cmd_q)
      CmdFwd:   begin tgt_l = base; tgt_r = base; end
      CmdLeft:  begin tdir_l = 1'b0; tgt_l = half; tgt_r = half; end
      CmdRight: begin tdir_r = 1'b0; tgt_l = half; tgt_r = half; end
      CmdArcL:  begin tgt_l = half; tgt_r = base; end
      CmdArcR:  begin tgt_l = base; tgt_r = half; end
      default:  begin tdir_l = dir_l_q; tdir_r = dir_r_q; end
    endcase
  end

  // Returns {dir, duty}: brake to zero before reversing, otherwise slew toward target.
  function automatic logic [8:0] ramp_next(input logic dir_cur, input logic [7:0] duty_cur,
                                           input logic dir_tgt, input logic [7:0] duty_tgt);
    logic [8:0] cur, tgt, nxt;
    logic       dir_n;
    cur   = {1'b0, duty_cur};
    tgt   = {1'b0, duty_tgt};
    nxt   = cur;
    dir_n = dir_cur;
    if (dir_tgt != dir_cur) begin
      if (cur != 9'd0) nxt = (cur > Step) ? cur - Step : 9'd0;
      else dir_n = dir_tgt;
    end else if (cur < tgt) begin
      nxt = cur + Step;
      if (nxt > tgt) nxt = tgt;
    end else if (cur > tgt) begin
      nxt = (cur > tgt + Step) ? cur - Step : tgt;
    end
    return {dir_n, (nxt > 9'd255) ? 8'hFF : nxt[7:0]};
  endfunction

  logic       tick;
  logic [8:0] ramp_l, ramp_r;

  always_comb begin
    tick     = (tick_q == TickMax);
    tick_d   = tick ? '0 : tick_q + 1'b1;
    ramp_l   = ramp_next(dir_l_q, duty_l_q, tdir_l, tgt_l);
    ramp_r   = ramp_next(dir_r_q, duty_r_q, tdir_r, tgt_r);
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    dir_l_d  = dir_l_q;
    dir_r_d  = dir_r_q;
    if (e_stop) begin
      duty_l_d = 8'd0;
      duty_r_d = 8'd0;
    end else if (tick) begin
      {dir_l_d, duty_l_d} = ramp_l;
      {dir_r_d, duty_r_d} = ramp_r;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q   <= ModeIdle;
      cam_q    <= CamSearch;
      cmd_q    <= CmdStop;
      gear_q   <= 2'd0;
      wd_q     <= '0;
      lost_q   <= '0;
      tick_q   <= '0;
      duty_l_q <= 8'd0;
      duty_r_q <= 8'd0;
      dir_l_q  <= 1'b1;
      dir_r_q  <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      cam_q    <= cam_d;
      cmd_q    <= cmd_d;
      gear_q   <= gear_d;
      wd_q     <= wd_d;
      lost_q   <= lost_d;
      tick_q   <= tick_d;
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
      dir_l_q  <= dir_l_d;
      dir_r_q  <= dir_r_d;
    end
  end

  assign mode      = mode_q;
  assign cam_state = cam_q;
  assign drive_cmd = cmd_q;
  assign gear      = gear_q;
  assign duty_l    = duty_l_q;
  assign duty_r    = duty_r_q;
  assign dir_l     = dir_l_q;
  assign dir_r     = dir_r_q;
  assign moving    = (duty_l_q != 8'd0) || (duty_r_q != 8'd0);

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_drive_arbiter;

  localparam int To    = 100;
  localparam int Lost  = 50;
  localparam int RDiv  = 4;
  localparam int RStep = 4;

  localparam int SMode = 0, SCam = 1, SCmd = 2, SGear = 3, SDutyL = 4, SDutyR = 5;
  localparam int SDirL = 6, SDirR = 7, SMove = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       ir_valid = 1'b0;
  logic [7:0] ir_code = 8'h00;
  logic       cam_found = 1'b0;
  logic [1:0] cam_dir = 2'd0;
  logic       e_stop = 1'b0;
  logic [1:0] mode, cam_state, gear;
  logic [2:0] drive_cmd;
  logic [7:0] duty_l, duty_r;
  logic       dir_l, dir_r, moving;

  drive_arbiter #(
    .TIMEOUT_CYCLES(To),
    .LOST_CYCLES   (Lost),
    .RAMP_DIV      (RDiv),
    .RAMP_STEP     (RStep)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .ir_valid (ir_valid),
    .ir_code  (ir_code),
    .cam_found(cam_found),
    .cam_dir  (cam_dir),
    .e_stop   (e_stop),
    .mode     (mode),
    .cam_state(cam_state),
    .drive_cmd(drive_cmd),
    .gear     (gear),
    .duty_l   (duty_l),
    .duty_r   (duty_r),
    .dir_l    (dir_l),
    .dir_r    (dir_r),
    .moving   (moving)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rst_cyc = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic int read_sig(input int s);
    case (s)
      SMode:   return int'(mode);
      SCam:    return int'(cam_state);
      SCmd:    return int'(drive_cmd);
      SGear:   return int'(gear);
      SDutyL:  return int'(duty_l);
      SDutyR:  return int'(duty_r);
      SDirL:   return int'(dir_l);
      SDirR:   return int'(dir_r);
      default: return int'(moving);
    endcase
  endfunction

  // Monitor
  always @(negedge CLOCK_50) begin
    exp_t e;
    int   act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = read_sig(e.sig);
      checks++;
      if (act != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic exp_sig(input string name, input int sig, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [7:0] c);
    ir_code  = c;
    ir_valid = 1'b1;
    step(1);
    ir_valid = 1'b0;
  endtask

  // Advance n edges, refreshing the IR watchdog with a neutral code every 50
  task automatic run_keep(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 50 == 49) press(8'h00);
      else step(1);
    end
  endtask

  // Park just after a ramp-tick edge
  task automatic align();
    while (((cyc - rst_cyc) % RDiv) != 0) step(1);
  endtask

  initial begin
    // Reset state
    step(2);
    exp_sig("rst_mode", SMode, 0);
    exp_sig("rst_cam", SCam, 0);
    exp_sig("rst_cmd", SCmd, 0);
    exp_sig("rst_gear", SGear, 0);
    exp_sig("rst_duty_l", SDutyL, 0);
    exp_sig("rst_duty_r", SDutyR, 0);
    exp_sig("rst_dir_l", SDirL, 1);
    exp_sig("rst_dir_r", SDirR, 1);
    exp_sig("rst_moving", SMove, 0);
    reset = 1'b0;
    rst_cyc = cyc;

    // IR drive, ramp and watchdog
    press(8'h0F);
    exp_sig("ir_mode", SMode, 1);
    exp_sig("ir_cmd_stop", SCmd, 0);
    align();
    press(8'h05);
    exp_sig("fwd_cmd", SCmd, 1);
    exp_sig("fwd_duty0", SDutyL, 0);
    step(3);
    exp_sig("ramp1_l", SDutyL, 4);
    exp_sig("ramp1_r", SDutyR, 4);
    exp_sig("ramp1_moving", SMove, 1);
    step(4);
    exp_sig("ramp2_l", SDutyL, 8);
    step(73);
    exp_sig("settle_l", SDutyL, 63);
    exp_sig("settle_r", SDutyR, 63);
    exp_sig("settle_cmd", SCmd, 1);
    step(19);
    exp_sig("wd_before", SCmd, 1);
    step(1);
    exp_sig("wd_expire", SCmd, 0);
    step(3);
    exp_sig("wd_down_l", SDutyL, 59);
    exp_sig("wd_down_r", SDutyR, 59);
    step(80);
    exp_sig("wd_zero_l", SDutyL, 0);
    exp_sig("wd_zero_mv", SMove, 0);
    exp_sig("wd_dir_l", SDirL, 1);

    // Gear limits and direction reversal
    repeat (4) press(8'h1A);
    exp_sig("gear_sat3", SGear, 3);
    press(8'h1E);
    exp_sig("gear_dn2", SGear, 2);
    press(8'h1A);
    press(8'h05);
    run_keep(300);
    exp_sig("g3_l", SDutyL, 255);
    exp_sig("g3_r", SDutyR, 255);
    align();
    press(8'h07);
    exp_sig("left_cmd", SCmd, 2);
    run_keep(99);
    exp_sig("rev_mid_l", SDutyL, 155);
    exp_sig("rev_mid_r", SDutyR, 155);
    exp_sig("rev_mid_dir", SDirL, 1);
    run_keep(157);
    exp_sig("rev_zero_l", SDutyL, 0);
    exp_sig("rev_zero_dir", SDirL, 1);
    exp_sig("rev_r_127", SDutyR, 127);
    run_keep(4);
    exp_sig("rev_flip_dir", SDirL, 0);
    exp_sig("rev_flip_duty", SDutyL, 0);
    run_keep(4);
    exp_sig("rev_up_l", SDutyL, 4);
    run_keep(136);
    exp_sig("rev_end_l", SDutyL, 127);
    exp_sig("rev_end_dir_l", SDirL, 0);
    exp_sig("rev_end_dir_r", SDirR, 1);

    // E-stop
    press(8'h1E);
    press(8'h05);
    run_keep(400);
    exp_sig("g2_l", SDutyL, 191);
    exp_sig("g2_r", SDutyR, 191);
    exp_sig("g2_dir_l", SDirL, 1);
    e_stop = 1'b1;
    step(1);
    exp_sig("estop_l", SDutyL, 0);
    exp_sig("estop_r", SDutyR, 0);
    exp_sig("estop_cmd", SCmd, 0);
    e_stop = 1'b0;
    run_keep(60);
    exp_sig("estop_after_cmd", SCmd, 0);
    exp_sig("estop_after_l", SDutyL, 0);
    exp_sig("estop_after_mode", SMode, 1);

    // Reset mid-ramp
    press(8'h05);
    step(20);
    reset = 1'b1;
    step(1);
    exp_sig("midrst_l", SDutyL, 0);
    exp_sig("midrst_r", SDutyR, 0);
    exp_sig("midrst_mode", SMode, 0);
    exp_sig("midrst_gear", SGear, 0);
    reset = 1'b0;
    rst_cyc = cyc;

    // IDLE ignores drive buttons; CAM sequencing
    press(8'h05);
    exp_sig("idle_ignore", SCmd, 0);
    press(8'h1A);
    press(8'h1A);
    exp_sig("idle_gear", SGear, 2);
    press(8'h13);
    exp_sig("cam_mode", SMode, 2);
    exp_sig("cam_search", SCam, 0);
    exp_sig("cam_enter_stop", SCmd, 0);
    step(1);
    exp_sig("search_left", SCmd, 2);
    press(8'h05);
    exp_sig("cam_ignore_drive", SCmd, 2);
    step(100);
    exp_sig("search_l", SDutyL, 31);
    exp_sig("search_dir_l", SDirL, 0);
    exp_sig("search_r", SDutyR, 31);
    cam_found = 1'b1;
    cam_dir = 2'd2;
    step(1);
    exp_sig("follow_state", SCam, 1);
    exp_sig("follow_arcr", SCmd, 5);
    cam_dir = 2'd0;
    step(1);
    exp_sig("follow_arcl", SCmd, 4);
    cam_dir = 2'd3;
    step(1);
    exp_sig("follow_fwd3", SCmd, 1);
    cam_found = 1'b0;
    step(Lost - 1);
    exp_sig("lost_before", SCam, 1);
    step(1);
    exp_sig("lost_search", SCam, 0);
    exp_sig("lost_left", SCmd, 2);
    press(8'h1B);
    exp_sig("pause_state", SCam, 3);
    exp_sig("pause_stop", SCmd, 0);
    press(8'h1F);
    exp_sig("resume_state", SCam, 0);
    exp_sig("resume_left", SCmd, 2);

    // Same-cycle mode button with e_stop; gear under e_stop
    e_stop = 1'b1;
    press(8'h10);
    exp_sig("same_mode", SMode, 0);
    exp_sig("same_cmd", SCmd, 0);
    exp_sig("same_cam", SCam, 0);
    press(8'h1E);
    exp_sig("estop_gear", SGear, 1);
    e_stop = 1'b0;
    repeat (4) press(8'h1A);
    exp_sig("gear_top", SGear, 3);
    press(8'h1E);
    exp_sig("gear_final", SGear, 2);

    for (int i = 0; i < 5 && sb.size() > 0; i++) step(1);
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_arbiter.md
# drive_arbiter

Owns the robot's two motor channels and decides, every cycle, which source drives them. It takes decoded IR-remote button codes and camera tracking status, and runs the top-level mode FSM (IDLE / IR / CAM) with a CAM sub-FSM, a gear selector and an IR command watchdog. It feeds the PWM generators with ramped per-wheel duty and direction. It sits between the IR decoder / camera tracker and the motor PWM stage.

## Interface
- TIMEOUT_CYCLES, 10_000_000: IR drive command expires after this many cycles without a new `ir_valid`.
- LOST_CYCLES, 25_000_000: consecutive cycles of `cam_found`=0 before FOLLOW falls back to SEARCH.
- RAMP_DIV, 50_000: cycles per ramp tick.
- RAMP_STEP, 4: maximum duty change per ramp tick.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ir_valid  in  1  one-cycle pulse; `ir_code` is valid.
- ir_code  in  8  button code.
- cam_found  in  1  target visible.
- cam_dir  in  2  target position: 0 = left, 1 = centre, 2 = right, 3 = treat as centre.
- e_stop  in  1  obstacle too close (level).
- mode  out  2  0 = IDLE, 1 = IR, 2 = CAM.
- cam_state  out  2  0 = SEARCH, 1 = FOLLOW, 3 = PAUSE.
- drive_cmd  out  3  0 = STOP, 1 = FWD, 2 = LEFT (spin), 3 = RIGHT (spin), 4 = ARC_L, 5 = ARC_R.
- gear  out  2  0..3.
- duty_l, duty_r  out  8  ramped wheel duty.
- dir_l, dir_r  out  1  1 = forward.
- moving  out  1  `duty_l`≠0 or `duty_r`≠0.

## Operation
- **Reset values:** mode=IDLE, cam_state=SEARCH, drive_cmd=STOP, gear=0, duties=0, dirs=1, all counters 0.
- **Mode FSM** (on `ir_valid`):
  - 0x0F sets IR.
  - 0x13 sets CAM.
  - 0x10 sets IDLE.
  - Entering the current mode again is a no-op.
  - Any mode change: drive_cmd=STOP, cam_state=SEARCH, watchdog and lost counters cleared.
- **IR mode:**
  - 0x05 sets FWD, 0x07 LEFT, 0x09 RIGHT, 0x04 ARC_L, 0x06 ARC_R, 0x08 STOP.
  - Every `ir_valid` (any code) clears the watchdog.
  - When the watchdog reaches TIMEOUT_CYCLES-1, drive_cmd becomes STOP.
- **CAM mode:**
  - SEARCH: drive_cmd=LEFT at an effective gear of 0. `cam_found` moves to FOLLOW.
  - FOLLOW: `cam_dir` 0 gives ARC_L, 1 or 3 gives FWD, 2 gives ARC_R.
  - FOLLOW: the lost counter increments while `cam_found`=0 and clears when it is 1. At LOST_CYCLES-1 the FSM goes to SEARCH.
  - Button 0x1B from SEARCH or FOLLOW goes to PAUSE (drive_cmd=STOP). Button 0x1F from PAUSE goes to SEARCH.
  - IR drive buttons are ignored in CAM mode.
- **IDLE mode:** drive_cmd=STOP; drive buttons are ignored.
- **Gear:** 0x1A increments, 0x1E decrements, in any mode. Saturates at 3 and 0.
- **Per-cycle priority:** reset > mode button > e_stop > drive/gear/pause button > watchdog/lost timeout.
- **e_stop=1:**
  - drive_cmd=STOP; duties forced to 0 on the next cycle, bypassing the ramp.
  - In IR mode the latched command is cleared to STOP and stays STOP after `e_stop` falls.
  - Mode and gear buttons are still honoured.
- **Target duty:** base B = 64·(gear+1)−1 (63, 127, 191, 255). H = B>>1.

  | drive_cmd | dir_l / dir_r | duty_l / duty_r |
  |---|---|---|
  | FWD | 1 / 1 | B / B |
  | LEFT | 0 / 1 | H / H |
  | RIGHT | 1 / 0 | H / H |
  | ARC_L | 1 / 1 | H / B |
  | ARC_R | 1 / 1 | B / H |
  | STOP | unchanged | 0 / 0 |

- **Ramp** (per wheel, on each ramp tick):
  - If the target direction differs from `dir_x` and `duty_x`>0: ramp toward 0.
  - If the target direction differs and `duty_x`=0: flip `dir_x` (duty stays 0 that tick).
  - Otherwise: step toward the target by at most RAMP_STEP, never overshooting.
  - Arithmetic uses a 9-bit intermediate clamped to 0..255.

## Timing
- `mode`, `cam_state`, `drive_cmd` and `gear` are registered. A qualifying input is visible the cycle after the sampling edge (latency 1).
- The ramp tick counter runs freely from 0 to RAMP_DIV-1 and wraps. A tick occurs at the wrap, so the first tick comes RAMP_DIV cycles after reset.
- Duty updates only on ticks, except the e_stop force-to-0.
- Reset asserted mid-ramp zeroes duties on the next edge.
- Watchdog and lost counters saturate; they do not wrap.

## Test plan
- **IR drive:** After reset, `ir_code` 0x0F then 0x05 → mode=1, drive_cmd=1. With gear=0, duties rise 4/tick to 63 and stop there; `moving`=1.
- **Watchdog:** IR mode, FWD, no further `ir_valid` for TIMEOUT_CYCLES (bench with 100) → drive_cmd=0 exactly at count 99, then duties ramp down to 0.
- **Direction reversal:** gear=3, FWD settled at 255, then 0x07 (LEFT) → `duty_l` ramps down to 0, `dir_l` flips to 0, `duty_l` ramps up to 127; `duty_r` ramps down to 127 with `dir_r` unchanged.
- **CAM sequencing:** 0x13 → cam_state=SEARCH, drive_cmd=LEFT. `cam_found`=1, `cam_dir`=2 → FOLLOW, ARC_R. `cam_found`=0 for LOST_CYCLES → SEARCH. Then 0x1B → PAUSE/STOP; 0x1F → SEARCH.
- **E-stop:** `e_stop`=1 while moving at 191 → duties 0 the next cycle, drive_cmd=0. After `e_stop` falls, drive_cmd stays 0 in IR mode.
- **Same-cycle events and gear limits:** 0x10 pulse in the same cycle as `e_stop` → mode=IDLE, drive_cmd=STOP. Four 0x1A presses → gear=3; one 0x1E → gear=2.
